// File: rtl/press_pattern_decoder_pkg.sv
// Purpose: shared state encoding and width derivations for the press pattern decoder and its consumers.
// Latency: not applicable (declarations only).
// Backpressure: not applicable; consumers size their evt_count input with cnt_w().
package io_defs;

  // FSM state encoding, held in a 2-bit register.
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] REPORT  = 2'd2;

  // Width of the press count, which must be able to hold 0..max_presses.
  function automatic int cnt_w(input int max_presses);
    return $clog2(max_presses + 1);
  endfunction

  // Width of the inter-press timer, which only has to reach window_count-1.
  function automatic int tmr_w(input int window_count);
    return $clog2(window_count);
  endfunction

endpackage

// File: rtl/press_pattern_decoder_window_timer.sv
// Purpose: inter-press window timer; flags expiry when the count reaches WINDOW_COUNT-1.
// Latency: expired is decoded from the registered count, so it is valid one edge after the count gets there.
// Backpressure: none; clear has priority over enable.
// Ports: sys_clk, rst_n (async, active low), clear (restart at 0), enable (advance by one),
//        expired (count == WINDOW_COUNT-1).
module press_window_timer
  import io_defs::*;
#(
  parameter int WINDOW_COUNT = 1_000_000
) (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int TMR_W = tmr_w(WINDOW_COUNT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(WINDOW_COUNT - 1);

  logic [TMR_W-1:0] tmr;

  // The owner clears on expiry, so tmr never wraps past TMR_LAST.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr <= '0;
    end else if (clear) begin
      tmr <= '0;
    end else if (enable) begin
      tmr <= tmr + 1'b1;
    end
  end

  assign expired = (tmr == TMR_LAST);

endmodule

// File: rtl/press_pattern_decoder.sv
// Purpose: groups debounced press pulses arriving within a sliding window into N-press events.
// Latency: event posts WINDOW_COUNT edges after the last press, or on the edge sampling the MAX_PRESSES-th press.
// Backpressure: event is held under evt_valid until evt_ack; presses arriving meanwhile are dropped and flagged on evt_lost.
// Ports: sys_clk, rst_n (async, active low), press_pulse (one-cycle pulse, polarity set by PRESS_ACTIVE_LOW),
//        evt_ack (consumer takes the event), evt_valid / evt_count (pending event and its press count),
//        evt_lost (one-cycle pulse for a dropped press). All outputs are registered.
module press_pattern_decoder
  import io_defs::*;
#(
  parameter int WINDOW_COUNT     = 1_000_000,
  parameter int MAX_PRESSES      = 3,
  parameter bit PRESS_ACTIVE_LOW = 1'b0
) (
  input  logic                           sys_clk,
  input  logic                           rst_n,
  input  logic                           press_pulse,
  input  logic                           evt_ack,
  output logic                           evt_valid,
  output logic [cnt_w(MAX_PRESSES)-1:0]  evt_count,
  output logic                           evt_lost
);

  localparam int CNT_W = cnt_w(MAX_PRESSES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PRESSES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             press;
  logic             expired;
  logic             valid_d;
  logic [CNT_W-1:0] count_d;
  logic             lost_d;

  assign press = PRESS_ACTIVE_LOW ? ~press_pulse : press_pulse;

  // A press restarts the window; expiry also restarts it so the timer never wraps.
  press_window_timer #(
    .WINDOW_COUNT(WINDOW_COUNT)
  ) u_timer (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .clear   (press || expired),
    .enable  (state == COLLECT),
    .expired (expired)
  );

  // State and count registers.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (press) begin
          cnt_next   = CNT_ONE;
          state_next = (MAX_PRESSES == 1) ? REPORT : COLLECT;
        end
      end
      COLLECT: begin
        // A press coincident with expiry is counted and keeps the burst open.
        if (press) begin
          cnt_next = cnt + 1'b1;
          if (cnt_next == CNT_MAX) begin
            state_next = REPORT;
          end
        end else if (expired) begin
          state_next = REPORT;
        end
      end
      REPORT: begin
        if (evt_ack) begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Output decode from the next state so the registered outputs line up with the state register.
  always_comb begin
    valid_d = (state_next == REPORT);
    count_d = valid_d ? cnt_next : '0;
    lost_d  = (state == REPORT) && press;
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_valid <= 1'b0;
      evt_count <= '0;
      evt_lost  <= 1'b0;
    end else begin
      evt_valid <= valid_d;
      evt_count <= count_d;
      evt_lost  <= lost_d;
    end
  end

endmodule

// File: tb/tb_press_pattern_decoder.sv
// Directed bench for press_pattern_decoder with WINDOW_COUNT=8, MAX_PRESSES=3, active-high presses.
// Cycle c is the c-th rising edge after reset release; stimulus set before edge c is sampled at edge c,
// and outputs are observed 1 time unit after edge c.
module tb_press_pattern_decoder;

  localparam int WC = 8;
  localparam int MP = 3;
  localparam int CW = 2;

  logic          sys_clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          press_pulse = 1'b0;
  logic          evt_ack = 1'b0;
  logic          evt_valid;
  logic [CW-1:0] evt_count;
  logic          evt_lost;

  int errors = 0;
  int checks = 0;

  always #5 sys_clk = ~sys_clk;

  press_pattern_decoder #(
    .WINDOW_COUNT(WC),
    .MAX_PRESSES(MP),
    .PRESS_ACTIVE_LOW(1'b0)
  ) dut (
    .sys_clk     (sys_clk),
    .rst_n       (rst_n),
    .press_pulse (press_pulse),
    .evt_ack     (evt_ack),
    .evt_valid   (evt_valid),
    .evt_count   (evt_count),
    .evt_lost    (evt_lost)
  );

  // Drive inputs, let one rising edge sample them, then settle past the edge.
  task automatic step(input logic p, input logic a);
    press_pulse = p;
    evt_ack = a;
    @(posedge sys_clk);
    #1;
  endtask

  // Reset for two edges, release off-edge; the next edge is cycle 1.
  task automatic restart();
    press_pulse = 1'b0;
    evt_ack = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (evt_valid !== 1'b0 || evt_count !== 2'd0 || evt_lost !== 1'b0) begin
      errors++;
      $display("FAIL reset_async valid=%b count=%0d lost=%b required 0/0/0", evt_valid, evt_count, evt_lost);
    end
    step(1'b1, 1'b1);
    checks++;
    if (evt_valid !== 1'b0 || evt_count !== 2'd0 || evt_lost !== 1'b0) begin
      errors++;
      $display("FAIL reset_held valid=%b count=%0d lost=%b required 0/0/0", evt_valid, evt_count, evt_lost);
    end
  endtask

  // Press at 10, ack at 25: event from 18 to 24 with count 1.
  task automatic test_single();
    logic ev; logic [CW-1:0] ec;
    restart();
    for (int c = 1; c <= 30; c++) begin
      step(c == 10, c == 25);
      ev = (c >= 18 && c <= 24);
      ec = ev ? 2'd1 : 2'd0;
      checks++;
      if (evt_valid !== ev || evt_count !== ec || evt_lost !== 1'b0) begin
        errors++;
        $display("FAIL single c=%0d valid=%b count=%0d lost=%b required %b/%0d/0", c, evt_valid, evt_count, evt_lost, ev, ec);
      end
    end
  endtask

  // Presses at 10 and 15 with ack held high: event only at 23 with count 2.
  task automatic test_double_ack_high();
    logic ev; logic [CW-1:0] ec;
    restart();
    for (int c = 1; c <= 28; c++) begin
      step(c == 10 || c == 15, 1'b1);
      ev = (c == 23);
      ec = ev ? 2'd2 : 2'd0;
      checks++;
      if (evt_valid !== ev || evt_count !== ec || evt_lost !== 1'b0) begin
        errors++;
        $display("FAIL double_ack_high c=%0d valid=%b count=%0d lost=%b required %b/%0d/0", c, evt_valid, evt_count, evt_lost, ev, ec);
      end
    end
  endtask

  // Presses at 10, 12, 14: event closes at 14 without waiting for the window, ack at 20.
  task automatic test_max_count();
    logic ev; logic [CW-1:0] ec;
    restart();
    for (int c = 1; c <= 24; c++) begin
      step(c == 10 || c == 12 || c == 14, c == 20);
      ev = (c >= 14 && c <= 19);
      ec = ev ? 2'd3 : 2'd0;
      checks++;
      if (evt_valid !== ev || evt_count !== ec || evt_lost !== 1'b0) begin
        errors++;
        $display("FAIL max_count c=%0d valid=%b count=%0d lost=%b required %b/%0d/0", c, evt_valid, evt_count, evt_lost, ev, ec);
      end
    end
  endtask

  // Second press at 18 coincides with window expiry: counted, event at 26 with count 2, ack at 30.
  task automatic test_coincident_expiry();
    logic ev; logic [CW-1:0] ec;
    restart();
    for (int c = 1; c <= 32; c++) begin
      step(c == 10 || c == 18, c == 30);
      ev = (c >= 26 && c <= 29);
      ec = ev ? 2'd2 : 2'd0;
      checks++;
      if (evt_valid !== ev || evt_count !== ec || evt_lost !== 1'b0) begin
        errors++;
        $display("FAIL coincident_expiry c=%0d valid=%b count=%0d lost=%b required %b/%0d/0", c, evt_valid, evt_count, evt_lost, ev, ec);
      end
    end
  endtask

  // Event pending from 18; presses at 20 and 22 (the ack cycle) are dropped; press at 23 starts
  // a new burst reported at 31, acked at 33.
  task automatic test_lost_back_to_back();
    logic ev; logic el; logic [CW-1:0] ec;
    restart();
    for (int c = 1; c <= 36; c++) begin
      step(c == 10 || c == 20 || c == 22 || c == 23, c == 22 || c == 33);
      ev = (c >= 18 && c <= 21) || (c >= 31 && c <= 32);
      ec = ev ? 2'd1 : 2'd0;
      el = (c == 20 || c == 22);
      checks++;
      if (evt_valid !== ev || evt_count !== ec || evt_lost !== el) begin
        errors++;
        $display("FAIL lost_back_to_back c=%0d valid=%b count=%0d lost=%b required %b/%0d/%b", c, evt_valid, evt_count, evt_lost, ev, ec, el);
      end
    end
  endtask

  // Presses at 10, 12, reset low for edges 14..16 discards the burst; press at 20 reports at 28.
  // Then reset is asserted mid-event and must clear the outputs at once.
  task automatic test_reset_mid();
    logic ev; logic [CW-1:0] ec;
    restart();
    for (int c = 1; c <= 29; c++) begin
      if (c == 14) begin
        rst_n = 1'b0;
        #1;
        checks++;
        if (evt_valid !== 1'b0 || evt_count !== 2'd0 || evt_lost !== 1'b0) begin
          errors++;
          $display("FAIL reset_mid_collect valid=%b count=%0d lost=%b required 0/0/0", evt_valid, evt_count, evt_lost);
        end
      end
      if (c == 17) rst_n = 1'b1;
      step(c == 10 || c == 12 || c == 20, 1'b0);
      ev = (c >= 28);
      ec = ev ? 2'd1 : 2'd0;
      checks++;
      if (evt_valid !== ev || evt_count !== ec || evt_lost !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid c=%0d valid=%b count=%0d lost=%b required %b/%0d/0", c, evt_valid, evt_count, evt_lost, ev, ec);
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (evt_valid !== 1'b0 || evt_count !== 2'd0 || evt_lost !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_report valid=%b count=%0d lost=%b required 0/0/0", evt_valid, evt_count, evt_lost);
    end
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_double_ack_high();
    test_max_count();
    test_coincident_expiry();
    test_lost_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
